max7219_write_scheduler: RTL and testbench

MAX7219_WRITE_SCHEDULER -- requirements
Module: max7219_write_scheduler

---
 rtl/max7219_write_scheduler.sv | 159 +++++++++++++++
 tb/tb_max7219_write_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_write_scheduler.sv
// Sequences MAX7219 register writes (configuration and digit frames) into
// single 16-bit words handed to a serializer with a stb/ack handshake.
module max7219_write_scheduler #(
  parameter int         NUM_DIGITS = 8,
  parameter logic [3:0] INTENSITY  = 4'h8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cfg_stb,
  input  logic                    i_update_stb,
  input  logic [8*NUM_DIGITS-1:0] i_digits,
  output logic                    o_word_stb,
  output logic [15:0]             o_word,
  input  logic                    i_word_ack,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  localparam int IDX_MAX = (NUM_DIGITS > 5) ? NUM_DIGITS : 5;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] CFG_LAST = IDX_W'(4);
  localparam logic [IDX_W-1:0] DIG_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_REQ,
    S_CFG_WAIT,
    S_DIG_REQ,
    S_DIG_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic                    word_stb_q, word_stb_d;
  logic [15:0]             word_q, word_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    cfg_pending_q, cfg_pending_d;
  logic                    upd_pending_q, upd_pending_d;
  logic [8*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  function automatic logic [15:0] cfg_word(input logic [IDX_W-1:0] idx);
    logic [15:0] w;
    case (idx)
      IDX_W'(0): w = 16'h0C01;
      IDX_W'(1): w = 16'h09FF;
      IDX_W'(2): w = {8'h0B, 8'(NUM_DIGITS - 1)};
      IDX_W'(3): w = {8'h0A, 4'h0, INTENSITY};
      default:   w = 16'h0F00;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] digit_word(input logic [8*NUM_DIGITS-1:0] snap,
                                             input logic [IDX_W-1:0]        idx);
    logic [15:0] w;
    w = 16'h0000;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (idx == IDX_W'(n)) begin
        w = {4'h0, 4'(n + 1), snap[8*n +: 8]};
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d       = state_q;
    word_stb_d    = word_stb_q;
    word_d        = word_q;
    frame_done_d  = 1'b0;
    snap_d        = snap_q;
    idx_d         = idx_q;
    cfg_pending_d = cfg_pending_q | i_cfg_stb;
    upd_pending_d = upd_pending_q | i_update_stb;

    case (state_q)
      S_IDLE: begin
        // A strobe on the very cycle its sequence starts stays pending.
        if (cfg_pending_q) begin
          state_d       = S_CFG_REQ;
          idx_d         = '0;
          cfg_pending_d = i_cfg_stb;
        end else if (upd_pending_q) begin
          state_d       = S_DIG_REQ;
          idx_d         = '0;
          upd_pending_d = i_update_stb;
          snap_d        = i_digits;
        end
      end
      S_CFG_REQ: begin
        word_stb_d = 1'b1;
        word_d     = cfg_word(idx_q);
        state_d    = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        if (i_word_ack) begin
          word_stb_d = 1'b0;
          idx_d      = idx_q + 1'b1;
          state_d    = (idx_q == CFG_LAST) ? S_IDLE : S_CFG_REQ;
        end
      end
      S_DIG_REQ: begin
        word_stb_d = 1'b1;
        word_d     = digit_word(snap_q, idx_q);
        state_d    = S_DIG_WAIT;
      end
      S_DIG_WAIT: begin
        if (i_word_ack) begin
          word_stb_d = 1'b0;
          idx_d      = idx_q + 1'b1;
          if (idx_q == DIG_LAST) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_DIG_REQ;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        word_stb_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Reset leaves a configuration request pending so the display is set up
  // automatically once reset is released.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      word_stb_q    <= 1'b0;
      word_q        <= 16'h0000;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      cfg_pending_q <= 1'b1;
      upd_pending_q <= 1'b0;
      snap_q        <= '0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      word_stb_q    <= word_stb_d;
      word_q        <= word_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      cfg_pending_q <= cfg_pending_d;
      upd_pending_q <= upd_pending_d;
      snap_q        <= snap_d;
      idx_q         <= idx_d;
    end
  end

  assign o_word_stb   = word_stb_q;
  assign o_word       = word_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_write_scheduler.sv
// Self-checking bench for max7219_write_scheduler: vector table, directed
// corner sequences and randomized transactions against a word-list model.
module tb_max7219_write_scheduler;

  localparam int         ND  = 8;
  localparam logic [3:0] INT = 4'h8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_stb = 1'b0;
  logic          upd_stb = 1'b0;
  logic          ack = 1'b0;
  logic [8*ND-1:0] digits = '0;
  logic          word_stb;
  logic [15:0]   word;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  max7219_write_scheduler #(.NUM_DIGITS(ND), .INTENSITY(INT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cfg_stb    (cfg_stb),
    .i_update_stb (upd_stb),
    .i_digits     (digits),
    .o_word_stb   (word_stb),
    .o_word       (word),
    .i_word_ack   (ack),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  typedef struct {
    bit          cfg;
    bit          upd;
    logic [63:0] dig;
    int          dly;
    logic [15:0] w;
    bit          done;
    bit          chk_idle;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    bit          done;
  } exp_t;

  vec_t tbl[13];
  exp_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] cfg_model(input int i);
    case (i)
      0:       return {8'h0C, 8'h01};
      1:       return {8'h09, 8'hFF};
      2:       return {8'h0B, 8'(ND - 1)};
      3:       return {8'h0A, 4'h0, INT};
      default: return {8'h0F, 8'h00};
    endcase
  endfunction

  function automatic logic [15:0] dig_model(input logic [63:0] d, input int n);
    return {4'h0, 4'(n + 1), d[8*n +: 8]};
  endfunction

  task automatic push_cfg();
    for (int i = 0; i < 5; i++) expq.push_back('{cfg_model(i), 1'b0});
  endtask

  task automatic push_frame(input logic [63:0] d);
    for (int n = 0; n < ND; n++) expq.push_back('{dig_model(d, n), (n == ND - 1)});
  endtask

  task automatic pulse_upd();
    upd_stb = 1'b1;
    @(negedge clk);
    upd_stb = 1'b0;
  endtask

  // Serializer model: wait for a request, check it, hold for dly cycles, ack.
  task automatic do_word(input logic [15:0] exp_w, input int dly, input bit exp_done,
                         input string nm);
    int          n;
    logic [15:0] held;
    bit          ok;
    n = 0;
    while (word_stb !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (word_stb !== 1'b1) begin
      chk({nm, "_stb_timeout"}, {31'd0, word_stb}, 32'd1);
      return;
    end
    chk({nm, "_word"}, {16'd0, word}, {16'd0, exp_w});
    held = word;
    ok = 1'b1;
    repeat (dly) begin
      @(negedge clk);
      if (word_stb !== 1'b1 || word !== held) ok = 1'b0;
    end
    chk({nm, "_hold"}, {31'd0, ok}, 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({nm, "_stb_drop"}, {31'd0, word_stb}, 32'd0);
    chk({nm, "_done"}, {31'd0, frame_done}, {31'd0, exp_done});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          c, u, mid;
    int          k;
    logic [63:0] d1, d2, da, db;

    // Rows 0-4: automatic config after reset; rows 5-12: one digit frame.
    tbl[0]  = '{0, 0, 64'h0, 0, 16'h0C01, 0, 0};
    tbl[1]  = '{0, 0, 64'h0, 0, 16'h09FF, 0, 0};
    tbl[2]  = '{0, 0, 64'h0, 0, 16'h0B07, 0, 0};
    tbl[3]  = '{0, 0, 64'h0, 0, 16'h0A08, 0, 0};
    tbl[4]  = '{0, 0, 64'h0, 0, 16'h0F00, 0, 1};
    tbl[5]  = '{0, 1, 64'h0706050403020100, 0, 16'h0100, 0, 0};
    tbl[6]  = '{0, 0, 64'h0706050403020100, 2, 16'h0201, 0, 0};
    tbl[7]  = '{0, 0, 64'h0706050403020100, 0, 16'h0302, 0, 0};
    tbl[8]  = '{0, 0, 64'h0706050403020100, 1, 16'h0403, 0, 0};
    tbl[9]  = '{0, 0, 64'h0706050403020100, 0, 16'h0504, 0, 0};
    tbl[10] = '{0, 0, 64'h0706050403020100, 3, 16'h0605, 0, 0};
    tbl[11] = '{0, 0, 64'h0706050403020100, 0, 16'h0706, 0, 0};
    tbl[12] = '{0, 0, 64'h0706050403020100, 0, 16'h0807, 1, 1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb", {31'd0, word_stb}, 32'd0);
    chk("rst_word", {16'd0, word}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].cfg || tbl[i].upd) begin
        digits  = tbl[i].dig;
        cfg_stb = tbl[i].cfg;
        upd_stb = tbl[i].upd;
        @(negedge clk);
        cfg_stb = 1'b0;
        upd_stb = 1'b0;
      end
      do_word(tbl[i].w, tbl[i].dly, tbl[i].done, $sformatf("tbl%0d", i));
      if (tbl[i].chk_idle) chk($sformatf("tbl%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // Simultaneous cfg+update: strobe latency, config first, one idle cycle.
    digits  = 64'h1122334455667788;
    cfg_stb = 1'b1;
    upd_stb = 1'b1;
    @(negedge clk);
    cfg_stb = 1'b0;
    upd_stb = 1'b0;
    chk("lat1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("lat2_busy", {31'd0, busy}, 32'd1);
    chk("lat2_stb", {31'd0, word_stb}, 32'd0);
    @(negedge clk);
    chk("lat3_stb", {31'd0, word_stb}, 32'd1);
    for (int i = 0; i < 5; i++) do_word(cfg_model(i), i % 2, 1'b0, $sformatf("both_cfg%0d", i));
    chk("gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("gap_restart_busy", {31'd0, busy}, 32'd1);
    chk("gap_restart_stb", {31'd0, word_stb}, 32'd0);
    for (int n = 0; n < ND; n++)
      do_word(dig_model(64'h1122334455667788, n), 0, n == ND - 1, $sformatf("both_dig%0d", n));

    // Data change and two update strobes mid-frame.
    da = 64'hA7A6A5A4A3A2A1A0;
    db = 64'hB7B6B5B4B3B2B1B0;
    digits = da;
    pulse_upd();
    for (int n = 0; n < ND; n++) begin
      if (n == 2) begin
        digits = db;
        pulse_upd();
      end
      if (n == 4) pulse_upd();
      do_word(dig_model(da, n), 1, n == ND - 1, $sformatf("old%0d", n));
    end
    for (int n = 0; n < ND; n++)
      do_word(dig_model(db, n), 0, n == ND - 1, $sformatf("new%0d", n));
    repeat (5) @(negedge clk);
    chk("collapse_busy", {31'd0, busy}, 32'd0);
    chk("collapse_stb", {31'd0, word_stb}, 32'd0);

    // Withheld ack, then reset during DIG_WAIT.
    digits = 64'h5A5A5A5A5A5A5A5A;
    pulse_upd();
    do_word(dig_model(64'h5A5A5A5A5A5A5A5A, 0), 20, 1'b0, "stall");
    k = 0;
    while (word_stb !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_pre_stb", {31'd0, word_stb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_stb", {31'd0, word_stb}, 32'd0);
    chk("midrst_word", {16'd0, word}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_hold_stb", {31'd0, word_stb}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) do_word(cfg_model(i), 0, 1'b0, $sformatf("postrst%0d", i));
    repeat (3) @(negedge clk);
    chk("postrst_idle", {31'd0, busy}, 32'd0);

    // Randomized transactions against the word-list model.
    for (int it = 0; it < 30; it++) begin
      c   = ($urandom % 2) == 1;
      u   = ($urandom % 2) == 1;
      if (!c && !u) u = 1'b1;
      d1  = {$urandom, $urandom};
      d2  = {$urandom, $urandom};
      mid = ($urandom % 2) == 1;
      k   = -1;
      if (mid) begin
        if (c && (!u || ($urandom % 2) == 1)) k = 1 + int'($urandom % 4);
        else k = (c ? 5 : 0) + 1 + int'($urandom % (ND - 1));
      end
      expq.delete();
      if (c) push_cfg();
      if (mid && c && k < 5) begin
        push_frame(d2);
      end else begin
        if (u) push_frame(d1);
        if (mid) push_frame(d2);
      end
      digits  = d1;
      cfg_stb = c;
      upd_stb = u;
      @(negedge clk);
      cfg_stb = 1'b0;
      upd_stb = 1'b0;
      for (int i = 0; i < expq.size(); i++) begin
        if (mid && i == k) begin
          digits = d2;
          pulse_upd();
          @(negedge clk);
          pulse_upd();
        end
        do_word(expq[i].w, int'($urandom % 4), expq[i].done, $sformatf("rnd%0d_w%0d", it, i));
      end
      repeat (3) @(negedge clk);
      chk($sformatf("rnd%0d_idle", it), {31'd0, busy}, 32'd0);
      chk($sformatf("rnd%0d_nostb", it), {31'd0, word_stb}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
